// File: rtl/hamming_scrub_ctrl.sv
// ECC scrubber for a Hamming(15,11) protected memory: walks an address range,
// passes each codeword through an external decoder and writes back corrected words.
module hamming_scrub_ctrl #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [14:0]       mem_rdata,
    output logic              mem_we,
    output logic [14:0]       mem_wdata,
    output logic [14:0]       dec_in,
    input  logic [14:0]       dec_out,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] last;
    logic [14:0]       word;

    // The decoder always sees the captured word, so its output is settled during CHECK.
    assign dec_in = word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            word      <= '0;
            err_cnt   <= '0;
            addr      <= '0;
            last      <= '0;
        end else begin
            // NOTE: strobes default low with non-blocking assignments; a later
            // assignment in the same block wins, giving single-cycle pulses.
            mem_rd_en <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr    <= base_addr;
                        last    <= last_addr;
                        err_cnt <= '0;
                        busy    <= 1'b1;
                        if (base_addr > last_addr) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_addr;
                        end
                    end
                end

                S_READ: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // An abort here drops the returning read data.
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        word  <= mem_rdata;
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (dec_out != word) begin
                        mem_wdata <= dec_out;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        if (err_cnt != {CNT_W{1'b1}})
                            err_cnt <= err_cnt + 1'b1;
                        state <= S_WRITE;
                    end else begin
                        state <= S_NEXT;
                    end
                end

                S_WRITE: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    // Compare before incrementing so a range ending at all-ones never wraps.
                    if (abort || addr == last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        addr      <= addr + 1'b1;
                        mem_addr  <= addr + 1'b1;
                        mem_rd_en <= 1'b1;
                        state     <= S_READ;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl with a behavioural memory, a Hamming(15,11)
// decoder model and a write scoreboard.
module tb_hamming_scrub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  base_addr;
    logic [7:0]  last_addr;
    logic        busy;
    logic        done;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [14:0] mem_rdata;
    logic        mem_we;
    logic [14:0] mem_wdata;
    logic [14:0] dec_in;
    logic [14:0] dec_out;
    logic [15:0] err_cnt;

    hamming_scrub_ctrl #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .last_addr (last_addr),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .dec_in    (dec_in),
        .dec_out   (dec_out),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [14:0] d;
    } wr_t;

    logic [14:0] mem [256];
    wr_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    int          rd_zero  = 0;
    int          max_rd   = 0;
    int          min_rd   = 255;
    int          cyc      = 0;

    // Single-error-correcting decoder: syndrome is the XOR of set bit positions (1..15).
    function automatic logic [14:0] hdec(input logic [14:0] c);
        logic [3:0]  s;
        logic [14:0] r;
        s = 4'd0;
        r = c;
        for (int i = 0; i < 15; i++)
            if (c[i]) s = s ^ 4'(i + 1);
        if (s != 4'd0) r[s - 4'd1] = ~r[s - 4'd1];
        return r;
    endfunction

    assign dec_out = hdec(dec_in);

    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_rdata <= mem[mem_addr];
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_rd_en === 1'b1 || mem_we === 1'b1)
                check("rd_we_exclusive", 32'(mem_rd_en & mem_we), 32'd0);
            if (mem_rd_en === 1'b1) begin
                rd_cnt++;
                if (mem_addr == 8'd0) rd_zero++;
                if (int'(mem_addr) > max_rd) max_rd = int'(mem_addr);
                if (int'(mem_addr) < min_rd) min_rd = int'(mem_addr);
            end
            if (mem_we === 1'b1) begin
                wr_t e;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("write_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(e.a));
                    check("write_data", 32'(mem_wdata), 32'(e.d));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_stats();
        rd_cnt  = 0;
        wr_cnt  = 0;
        rd_zero = 0;
        max_rd  = 0;
        min_rd  = 255;
    endtask

    task automatic start_pass(input logic [7:0] b, input logic [7:0] l);
        base_addr = b;
        last_addr = l;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 300) step();
        if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = 8'd0;
        last_addr = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] <= 15'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", 32'({mem_rd_en, mem_we}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_dec_in", 32'(dec_in), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Clean 4-word pass; a start pulse mid-pass must be ignored.
        clear_stats();
        start_pass(8'd0, 8'd3);
        check("t1_busy", 32'(busy), 32'd1);
        while (cyc < 5) step();
        base_addr = 8'd100;
        last_addr = 8'd100;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        check("t1_done_cycle", 32'(cyc), 32'd17);
        check("t1_err_cnt", 32'(err_cnt), 32'd0);
        check("t1_rd_cnt", 32'(rd_cnt), 32'd4);
        check("t1_addr_range", 32'({max_rd[7:0], min_rd[7:0]}), 32'h0300);
        step();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd0);

        // Single corrected word.
        mem[5] <= 15'h0020;
        exp_q.push_back('{a: 8'd5, d: 15'h0000});
        step();
        clear_stats();
        start_pass(8'd5, 8'd5);
        wait_done();
        check("t2_done_cycle", 32'(cyc), 32'd6);
        check("t2_err_cnt", 32'(err_cnt), 32'd1);
        check("t2_wr_cnt", 32'(wr_cnt), 32'd1);
        step();
        check("t2_mem5", 32'(mem[5]), 32'd0);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Range ending at 255 must not wrap to address 0.
        mem[255] <= 15'h7FFE;
        mem[0]   <= 15'h0020;
        exp_q.push_back('{a: 8'd255, d: 15'h7FFF});
        step();
        clear_stats();
        start_pass(8'd254, 8'd255);
        wait_done();
        check("t3_done_cycle", 32'(cyc), 32'd10);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        check("t3_no_wrap", 32'(rd_zero), 32'd0);
        step();
        check("t3_busy_after", 32'(busy), 32'd0);
        check("t3_mem255", 32'(mem[255]), 32'h7FFF);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);
        mem[0] <= 15'h0000;

        // Empty range: straight to DONE.
        step();
        clear_stats();
        start_pass(8'd9, 8'd4);
        check("t4_done", 32'(done), 32'd1);
        step();
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_strobes", 32'(rd_cnt + wr_cnt), 32'd0);
        check("t4_err_cnt", 32'(err_cnt), 32'd0);

        // Abort during third word's WAIT.
        clear_stats();
        start_pass(8'd16, 8'd31);
        while (cyc < 10) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_done", 32'(done), 32'd1);
        check("t5_max_addr", 32'(max_rd), 32'd18);
        check("t5_rd_cnt", 32'(rd_cnt), 32'd3);
        step();
        check("t5_busy_after", 32'(busy), 32'd0);

        // Abort during WRITE: write completes, then done.
        mem[40] <= 15'h0020;
        exp_q.push_back('{a: 8'd40, d: 15'h0000});
        step();
        clear_stats();
        start_pass(8'd40, 8'd45);
        while (cyc < 4) step();
        check("t5w_in_write", 32'(mem_we), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5w_done", 32'(done), 32'd1);
        check("t5w_wr_cnt", 32'(wr_cnt), 32'd1);
        step();
        check("t5w_mem40", 32'(mem[40]), 32'd0);
        check("t5w_q_empty", 32'(exp_q.size()), 32'd0);

        // start and abort together in IDLE: start wins and the pass runs normally.
        clear_stats();
        abort = 1'b1;
        start_pass(8'd50, 8'd50);
        abort = 1'b0;
        check("t5s_busy", 32'(busy), 32'd1);
        wait_done();
        check("t5s_done_cycle", 32'(cyc), 32'd5);
        check("t5s_rd_cnt", 32'(rd_cnt), 32'd1);
        step();

        // Reset during CHECK of a word needing correction.
        mem[60] <= 15'h0020;
        step();
        clear_stats();
        start_pass(8'd60, 8'd62);
        while (cyc < 3) step();
        rst = 1'b1;
        step();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_strobes", 32'({mem_rd_en, mem_we}), 32'd0);
        check("t6_addr", 32'(mem_addr), 32'd0);
        check("t6_wdata", 32'(mem_wdata), 32'd0);
        check("t6_dec_in", 32'(dec_in), 32'd0);
        check("t6_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        repeat (4) step();
        check("t6_no_write", 32'(wr_cnt), 32'd0);
        check("t6_mem60", 32'(mem[60]), 32'h0020);
        check("t6_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
